// File: rtl/hwpe_stream_realign_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : hwpe_stream_realign_sequencer
// Brief   : Per-transfer control-word and reference-strobe generator for the
//           stream sink realigner.
// Revision: 1.0
// ============================================================================
module hwpe_stream_realign_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned NB        = DATA_WIDTH / 8,
  localparam int unsigned OFFS_W    = $clog2(NB)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic                  handshake_i,
  // ctrl_o = {enable, realign, first, last}
  output logic [3:0]            ctrl_o,
  output logic [NB-1:0]         strb_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [NB-1:0] c_all_ones = {NB{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [OFFS_W-1:0]   r_off;
  logic [CNT_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                r_realign;

  logic                w_first;
  logic                w_last_beat;
  logic [NB-1:0]       w_head_strb;
  logic                w_unused_addr;

  assign w_first       = (r_cnt == '0);
  assign w_last_beat   = (r_cnt == (r_len - CNT_WIDTH'(1)));
  assign w_head_strb   = c_all_ones << r_off;
  assign w_unused_addr = ^addr_i[ADDR_WIDTH-1:OFFS_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_off     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_realign <= 1'b0;
    end else if (clear_i) begin
      r_state   <= ST_IDLE;
      r_off     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_realign <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_off     <= addr_i[OFFS_W-1:0];
            r_len     <= len_i;
            r_realign <= |addr_i[OFFS_W-1:0];
            r_cnt     <= '0;
            r_state   <= (len_i != '0) ? ST_STREAM : ST_DONE;
          end
        end
        ST_STREAM: begin
          // Counter holds at len-1 so the final beat decision never wraps.
          if (handshake_i) begin
            if (w_last_beat) begin
              r_state <= r_realign ? ST_FLUSH : ST_DONE;
            end else begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (handshake_i) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_o = 4'b0000;
    strb_o = '0;
    case (r_state)
      ST_STREAM: begin
        ctrl_o = {1'b1, r_realign, w_first, 1'b0};
        strb_o = w_first ? w_head_strb : c_all_ones;
      end
      ST_FLUSH: begin
        // Low off bytes: the tail left over from the last shifted word.
        ctrl_o = 4'b1101;
        strb_o = ~w_head_strb;
      end
      ST_DONE: begin
        ctrl_o = 4'b1000;
      end
      default: begin
        ctrl_o = 4'b0000;
        strb_o = '0;
      end
    endcase
  end

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_realign_sequencer.sv
`default_nettype none
// Directed bench for hwpe_stream_realign_sequencer (32-bit stream):
// per-cycle vector table plus hand-written multi-cycle sequences.
module tb_hwpe_stream_realign_sequencer;

  logic        clk_i       = 1'b0;
  logic        rst_ni      = 1'b0;
  logic        clear_i     = 1'b0;
  logic        start_i     = 1'b0;
  logic [31:0] addr_i      = '0;
  logic [15:0] len_i       = '0;
  logic        handshake_i = 1'b0;
  logic [3:0]  ctrl_o;
  logic [3:0]  strb_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_pass   = 0;

  hwpe_stream_realign_sequencer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .addr_i     (addr_i),
    .len_i      (len_i),
    .handshake_i(handshake_i),
    .ctrl_o     (ctrl_o),
    .strb_o     (strb_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  // One row = inputs applied for the coming edge + outputs expected this cycle.
  typedef struct {
    string       name;
    logic        clr;
    logic        st;
    logic [31:0] addr;
    logic [15:0] len;
    logic        hs;
    logic [3:0]  ctrl;
    logic [3:0]  strb;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(string n, logic clr, logic st, logic [31:0] a,
                             logic [15:0] l, logic hs, logic [3:0] c,
                             logic [3:0] s, logic b, logic d);
    vec_t r;
    r.name = n; r.clr = clr; r.st = st; r.addr = a; r.len = l; r.hs = hs;
    r.ctrl = c; r.strb = s; r.busy = b; r.done = d;
    return r;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_outs(string tag, logic [3:0] c, logic [3:0] s,
                            logic b, logic d);
    chk({tag, " ctrl"}, ctrl_o, c);
    chk({tag, " strb"}, strb_o, s);
    chk({tag, " busy"}, {3'b000, busy_o}, {3'b000, b});
    chk({tag, " done"}, {3'b000, done_o}, {3'b000, d});
  endtask

  task automatic step(string tag, logic clr, logic st, logic [31:0] a,
                      logic [15:0] l, logic hs, logic [3:0] c, logic [3:0] s,
                      logic b, logic d);
    @(negedge clk_i);
    check_outs(tag, c, s, b, d);
    clear_i     = clr;
    start_i     = st;
    addr_i      = a;
    len_i       = l;
    handshake_i = hs;
  endtask

  initial begin
    // ctrl codes {en,realign,first,last}: A first/aligned, 8 mid/done,
    // E first/realign, C mid/realign, D flush
    // T1: aligned, len 3
    tbl.push_back(v("t1_start", 0, 1, 32'h100, 3, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v("t1_b0",    0, 0, 0, 0, 1, 4'hA, 4'hF, 1, 0));
    tbl.push_back(v("t1_b1",    0, 0, 0, 0, 1, 4'h8, 4'hF, 1, 0));
    tbl.push_back(v("t1_b2",    0, 0, 0, 0, 1, 4'h8, 4'hF, 1, 0));
    tbl.push_back(v("t1_done",  0, 0, 0, 0, 0, 4'h8, 4'h0, 1, 1));
    tbl.push_back(v("t1_idle",  0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0));
    // T2: offset 1, len 3
    tbl.push_back(v("t2_start", 0, 1, 32'h101, 3, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v("t2_b0",    0, 0, 0, 0, 1, 4'hE, 4'hE, 1, 0));
    tbl.push_back(v("t2_b1",    0, 0, 0, 0, 1, 4'hC, 4'hF, 1, 0));
    tbl.push_back(v("t2_b2",    0, 0, 0, 0, 1, 4'hC, 4'hF, 1, 0));
    tbl.push_back(v("t2_flush", 0, 0, 0, 0, 1, 4'hD, 4'h1, 1, 0));
    tbl.push_back(v("t2_done",  0, 0, 0, 0, 0, 4'h8, 4'h0, 1, 1));
    tbl.push_back(v("t2_idle",  0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0));
    // T4: len 0, handshake while idle ignored
    tbl.push_back(v("t4_start", 0, 1, 32'h102, 0, 1, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v("t4_done",  0, 0, 0, 0, 0, 4'h8, 4'h0, 1, 1));
    tbl.push_back(v("t4_idle",  0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0));
    // T5a: second start mid-transfer must be ignored
    tbl.push_back(v("t5a_start", 0, 1, 32'h102, 4, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v("t5a_b0",    0, 0, 0, 0, 1, 4'hE, 4'hC, 1, 0));
    tbl.push_back(v("t5a_b1",    0, 0, 0, 0, 1, 4'hC, 4'hF, 1, 0));
    tbl.push_back(v("t5a_b2",    0, 1, 32'h0, 1, 1, 4'hC, 4'hF, 1, 0));
    tbl.push_back(v("t5a_b3",    0, 0, 0, 0, 1, 4'hC, 4'hF, 1, 0));
    tbl.push_back(v("t5a_flush", 0, 0, 0, 0, 1, 4'hD, 4'h3, 1, 0));
    tbl.push_back(v("t5a_done",  0, 0, 0, 0, 0, 4'h8, 4'h0, 1, 1));
    tbl.push_back(v("t5a_idle",  0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0));
    // T5b: clear after 2 beats, clear beats start/handshake
    tbl.push_back(v("t5b_start", 0, 1, 32'h102, 4, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v("t5b_b0",    0, 0, 0, 0, 1, 4'hE, 4'hC, 1, 0));
    tbl.push_back(v("t5b_b1",    0, 0, 0, 0, 1, 4'hC, 4'hF, 1, 0));
    tbl.push_back(v("t5b_clr",   1, 1, 32'h101, 2, 1, 4'hC, 4'hF, 1, 0));
    tbl.push_back(v("t5b_idle0", 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0));
    tbl.push_back(v("t5b_idle1", 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0));

    repeat (2) @(negedge clk_i);
    check_outs("reset", 4'h0, 4'h0, 1'b0, 1'b0);
    rst_ni = 1'b1;

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].clr, tbl[i].st, tbl[i].addr, tbl[i].len,
           tbl[i].hs, tbl[i].ctrl, tbl[i].strb, tbl[i].busy, tbl[i].done);

    // T3: offset 3, len 1, handshakes delayed 5 cycles per beat
    step("t3_start", 0, 1, 32'h103, 1, 0, 4'h0, 4'h0, 0, 0);
    for (int k = 0; k < 5; k++) step("t3_hold0", 0, 0, 0, 0, 0, 4'hE, 4'h8, 1, 0);
    step("t3_b0", 0, 0, 0, 0, 1, 4'hE, 4'h8, 1, 0);
    for (int k = 0; k < 5; k++) step("t3_hold1", 0, 0, 0, 0, 0, 4'hD, 4'h7, 1, 0);
    step("t3_flush", 0, 0, 0, 0, 1, 4'hD, 4'h7, 1, 0);
    step("t3_done", 0, 0, 0, 0, 0, 4'h8, 4'h0, 1, 1);
    step("t3_idle", 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);

    // T6: asynchronous reset while in FLUSH, then a fresh transfer
    step("t6_start", 0, 1, 32'h101, 1, 0, 4'h0, 4'h0, 0, 0);
    step("t6_b0", 0, 0, 0, 0, 1, 4'hE, 4'hE, 1, 0);
    step("t6_flush", 0, 0, 0, 0, 0, 4'hD, 4'h1, 1, 0);
    #2 rst_ni = 1'b0;
    #1 check_outs("t6_async_rst", 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    check_outs("t6_in_rst", 4'h0, 4'h0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    step("t6_r_start", 0, 1, 32'h101, 2, 0, 4'h0, 4'h0, 0, 0);
    step("t6_r_b0", 0, 0, 0, 0, 1, 4'hE, 4'hE, 1, 0);
    step("t6_r_b1", 0, 0, 0, 0, 1, 4'hC, 4'hF, 1, 0);
    step("t6_r_flush", 0, 0, 0, 0, 1, 4'hD, 4'h1, 1, 0);
    step("t6_r_done", 0, 0, 0, 0, 0, 4'h8, 4'h0, 1, 1);
    step("t6_r_idle", 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
